qr_grant_arbiter: RTL and testbench
===================================

Name: qr_grant_arbiter

Overview:
- Two-requester round-robin arbiter that shares one enable-gated resource between requesters q and r.
- Produces the `en`/`valid` qualifiers that downstream assertion checkers sample on posedge clk.
- Enforces mutual exclusion, a bounded hold time per tenure, and a one-cycle valid pulse at the start of every tenure.
- Sits between the requester logic and the gated datapath.

Parameters:
- MAX_HOLD, 4, maximum consecutive cycles one owner keeps the grant while the other side is requesting; legal range 1..2**CNT_W.
- CNT_W, 3, width of the hold counter; must satisfy 2**CNT_W >= MAX_HOLD.

Ports:
- clk  input  1  clock, all state updates on posedge.
- rst_n  input  1  asynchronous active-low reset.
- arb_en  input  1  global arbitration enable; low forces release.
- q_req  input  1  level request from requester q.
- r_req  input  1  level request from requester r.
- gnt_q  output  1  registered grant to q.
- gnt_r  output  1  registered grant to r.
- en  output  1  resource enable; equals gnt_q | gnt_r.
- valid  output  1  one-cycle pulse in the first cycle of every new tenure.
- hold_cnt  output  CNT_W  cycles elapsed in the current tenure, 0-based.
- last_owner  output  1  0 = q, 1 = r; owner of the most recent grant.

Behaviour:
- Interface: single clock, clk. Reset is asynchronous and active-low, rst_n.
- Reset (async assert, sync deassert at next posedge) gives:
  - state IDLE;
  - gnt_q, gnt_r, en, valid, hold_cnt all 0;
  - last_owner = 1, so q wins the first tie.
- States: IDLE, OWN_Q, OWN_R. All outputs are registered. Latency from request to grant is 1 cycle.
- IDLE:
  - arb_en=1, one requester high: go to that owner.
  - arb_en=1, both high: go to the requester != last_owner.
  - arb_en=0 or no request: stay in IDLE.
- OWN_Q, with priority order:
  1. arb_en=0: go to IDLE.
  2. q_req=0: go to OWN_R if r_req=1 (and arb_en=1), else IDLE.
  3. hold_cnt == MAX_HOLD-1 and r_req=1: go to OWN_R (forced handover).
  4. Otherwise stay in OWN_Q.
- OWN_R: mirror image of OWN_Q with q and r swapped.
- Handover q<->r takes zero idle cycles; the new grant appears the cycle after the old one drops, with no overlap.
- hold_cnt:
  - cleared to 0 on entry to any owner state;
  - increments each cycle the owner is retained;
  - saturates at MAX_HOLD-1 when the other side is not requesting;
  - reads 0 in IDLE.
- valid = 1 exactly in the first cycle of each OWN_Q/OWN_R entry, including a direct handover. It is 0 in every other cycle.
- last_owner updates on entry to an owner state and holds through IDLE.
- Invariants:
  - gnt_q & gnt_r = 0 always;
  - valid -> en;
  - en -> (gnt_q | gnt_r);
  - a grant to a requester only follows a cycle in which that requester's req was high.
- MAX_HOLD=1 with both requesting: the grant alternates every cycle and valid is high every cycle.
- Reset asserted mid-tenure: all outputs clear immediately (asynchronously). The first grant after release goes to q on a tie.
- A request that toggles during a tenure does not affect the owner until the next posedge evaluation.

Optional Feature:
- Macro QR_ARB_SVA_EN.
- Defined: the module contains concurrent assertions, each disabled while !rst_n, that error via $error and report pass via $info:
  - mutual exclusion;
  - valid |-> en;
  - en |-> (gnt_q|gnt_r);
  - gnt_q rose |-> $past(q_req);
  - hold_cnt <= MAX_HOLD-1;
  - fairness: with both requests held high, no owner exceeds MAX_HOLD consecutive cycles.
- Undefined: no assertion code is compiled. RTL behaviour is identical.

Test Plan:
1. Reset, arb_en=1, q_req=1, r_req=0 for 3 cycles -> gnt_q=1 from cycle 1; valid=1 only in cycle 1; hold_cnt 0,1,2; en=1.
2. Both requests held high, MAX_HOLD=4 -> q owns 4 cycles (hold_cnt 0..3), then r owns 4, alternating; valid pulses at each switch; gnt never overlaps.
3. OWN_Q, q_req drops while r_req=1 -> next cycle gnt_r=1, valid=1, hold_cnt=0, last_owner=1.
4. OWN_R, arb_en driven 0 -> next cycle IDLE, en=0, gnt_r=0; re-enable with both requesting -> q granted (last_owner was 1).
5. rst_n pulsed low mid-tenure at hold_cnt=2 -> outputs 0 immediately; after release, a tie grants q first.
6. MAX_HOLD=1, both requesting for 6 cycles -> grants q,r,q,r,q,r; valid=1 every cycle; hold_cnt stays 0.

Source files
------------

// File: rtl/qr_grant_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : qr_grant_arbiter
// Description : Two-requester (q/r) round-robin arbiter with bounded hold
//               time and a one-cycle valid pulse per tenure.
//               Optional assertions enabled by macro QR_ARB_SVA_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module qr_grant_arbiter #(
    parameter int MAX_HOLD = 4,
    parameter int CNT_W    = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             arb_en,
    input  logic             q_req,
    input  logic             r_req,
    output logic             gnt_q,
    output logic             gnt_r,
    output logic             en,
    output logic             valid,
    output logic [CNT_W-1:0] hold_cnt,
    output logic             last_owner
);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_own_q = 2'd1;
    localparam logic [1:0] c_st_own_r = 2'd2;

    localparam logic [CNT_W-1:0] c_hold_max = CNT_W'(MAX_HOLD - 1);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_hold_cnt;
    logic             r_gnt_q;
    logic             r_gnt_r;
    logic             r_en;
    logic             r_valid;
    logic             r_last_owner;

    logic [1:0]       w_next_state;
    logic [CNT_W-1:0] w_next_hold;
    logic             w_next_valid;
    logic             w_next_last;

    // last_owner resets to r so that q wins the first tie
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= c_st_idle;
            r_hold_cnt   <= '0;
            r_gnt_q      <= 1'b0;
            r_gnt_r      <= 1'b0;
            r_en         <= 1'b0;
            r_valid      <= 1'b0;
            r_last_owner <= 1'b1;
        end else begin
            r_state      <= w_next_state;
            r_hold_cnt   <= w_next_hold;
            r_gnt_q      <= (w_next_state == c_st_own_q);
            r_gnt_r      <= (w_next_state == c_st_own_r);
            r_en         <= (w_next_state != c_st_idle);
            r_valid      <= w_next_valid;
            r_last_owner <= w_next_last;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle: begin
                if (arb_en) begin
                    if (q_req && r_req)
                        w_next_state = r_last_owner ? c_st_own_q : c_st_own_r;
                    else if (q_req)
                        w_next_state = c_st_own_q;
                    else if (r_req)
                        w_next_state = c_st_own_r;
                end
            end
            c_st_own_q: begin
                if (!arb_en)
                    w_next_state = c_st_idle;
                else if (!q_req)
                    w_next_state = r_req ? c_st_own_r : c_st_idle;
                else if ((r_hold_cnt == c_hold_max) && r_req)
                    w_next_state = c_st_own_r;
            end
            c_st_own_r: begin
                if (!arb_en)
                    w_next_state = c_st_idle;
                else if (!r_req)
                    w_next_state = q_req ? c_st_own_q : c_st_idle;
                else if ((r_hold_cnt == c_hold_max) && q_req)
                    w_next_state = c_st_own_q;
            end
            default: w_next_state = c_st_idle;
        endcase
    end

    // A tenure starts whenever the next state is an owner state different
    // from the current one, which covers direct q<->r handover as well.
    always_comb begin
        w_next_hold  = '0;
        w_next_valid = 1'b0;
        w_next_last  = r_last_owner;
        if (w_next_state != c_st_idle) begin
            if (w_next_state != r_state) begin
                w_next_valid = 1'b1;
                w_next_last  = (w_next_state == c_st_own_r);
            end else if (r_hold_cnt != c_hold_max) begin
                w_next_hold  = r_hold_cnt + CNT_W'(1);
            end else begin
                w_next_hold  = r_hold_cnt;
            end
        end
    end

    assign gnt_q      = r_gnt_q;
    assign gnt_r      = r_gnt_r;
    assign en         = r_en;
    assign valid      = r_valid;
    assign hold_cnt   = r_hold_cnt;
    assign last_owner = r_last_owner;

`ifdef QR_ARB_SVA_EN
    a_mutex: assert property (@(posedge clk) disable iff (!rst_n) !(gnt_q && gnt_r))
        $info("a_mutex pass"); else $error("a_mutex violated");
    a_valid_en: assert property (@(posedge clk) disable iff (!rst_n) valid |-> en)
        $info("a_valid_en pass"); else $error("a_valid_en violated");
    a_en_gnt: assert property (@(posedge clk) disable iff (!rst_n) en |-> (gnt_q || gnt_r))
        $info("a_en_gnt pass"); else $error("a_en_gnt violated");
    a_gnt_q_req: assert property (@(posedge clk) disable iff (!rst_n) $rose(gnt_q) |-> $past(q_req))
        $info("a_gnt_q_req pass"); else $error("a_gnt_q_req violated");
    a_hold_max: assert property (@(posedge clk) disable iff (!rst_n) hold_cnt <= c_hold_max)
        $info("a_hold_max pass"); else $error("a_hold_max violated");
    a_fair_q: assert property (@(posedge clk) disable iff (!rst_n)
            (gnt_q && arb_en && q_req && r_req && hold_cnt == c_hold_max) |=> !gnt_q)
        $info("a_fair_q pass"); else $error("a_fair_q violated");
    a_fair_r: assert property (@(posedge clk) disable iff (!rst_n)
            (gnt_r && arb_en && q_req && r_req && hold_cnt == c_hold_max) |=> !gnt_r)
        $info("a_fair_r pass"); else $error("a_fair_r violated");
`endif

endmodule
`default_nettype wire

// File: tb/tb_qr_grant_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_qr_grant_arbiter
// Description : Directed self-checking bench for qr_grant_arbiter
//               (MAX_HOLD=4 instance plus a MAX_HOLD=1 instance).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_qr_grant_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       arb_en, q_req, r_req;
    logic       gnt_q, gnt_r, en, valid, last_owner;
    logic [2:0] hold_cnt;

    logic       arb_en1, q_req1, r_req1;
    logic       gnt_q1, gnt_r1, en1, valid1, last_owner1;
    logic [0:0] hold_cnt1;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] obs, exp_v;
    logic [5:0] obs1, exp1;

    always #5 clk = ~clk;

    qr_grant_arbiter #(.MAX_HOLD(4), .CNT_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .arb_en(arb_en), .q_req(q_req), .r_req(r_req),
        .gnt_q(gnt_q), .gnt_r(gnt_r), .en(en), .valid(valid),
        .hold_cnt(hold_cnt), .last_owner(last_owner)
    );

    qr_grant_arbiter #(.MAX_HOLD(1), .CNT_W(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .arb_en(arb_en1), .q_req(q_req1), .r_req(r_req1),
        .gnt_q(gnt_q1), .gnt_r(gnt_r1), .en(en1), .valid(valid1),
        .hold_cnt(hold_cnt1), .last_owner(last_owner1)
    );

    // observed vector: {gnt_q, gnt_r, en, valid, hold_cnt[2:0], last_owner}
    always_comb obs  = {gnt_q, gnt_r, en, valid, hold_cnt, last_owner};
    always_comb obs1 = {gnt_q1, gnt_r1, en1, valid1, hold_cnt1, last_owner1};

    task automatic apply_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        arb_en = 0; q_req = 0; r_req = 0;
        arb_en1 = 0; q_req1 = 0; r_req1 = 0;
        rst_n = 1'b0;
        #12;
        exp_v = 8'b0000_000_1;
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL reset obs=%b exp=%b", obs, exp_v);
        end
        @(negedge clk);
        rst_n = 1'b1;
        // enabled but no request: stays idle
        arb_en = 1;
        @(negedge clk);
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL idle_no_req obs=%b exp=%b", obs, exp_v);
        end
    endtask

    task automatic test_single_req();
        arb_en = 1; q_req = 1; r_req = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            exp_v = {1'b1, 1'b0, 1'b1, (i == 0), 3'(i), 1'b0};
            n_tests++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL single_req_c%0d obs=%b exp=%b", i, obs, exp_v);
            end
        end
        // q alone past MAX_HOLD: hold counter saturates at 3
        for (int i = 3; i < 6; i++) begin
            @(negedge clk);
            exp_v = {1'b1, 1'b0, 1'b1, 1'b0, (i < 3) ? 3'(i) : 3'd3, 1'b0};
            n_tests++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL hold_sat_c%0d obs=%b exp=%b", i, obs, exp_v);
            end
        end
        q_req = 0;
        @(negedge clk);
        exp_v = 8'b0000_000_0;
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL release_idle obs=%b exp=%b", obs, exp_v);
        end
    endtask

    task automatic test_round_robin();
        q_req = 0; r_req = 0;
        apply_reset();
        arb_en = 1; q_req = 1; r_req = 1;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            exp_v = {((k / 4) % 2 == 0), ((k / 4) % 2 == 1), 1'b1, (k % 4 == 0),
                     3'(k % 4), ((k / 4) % 2 == 1)};
            n_tests++;
            if (obs !== exp_v || (gnt_q && gnt_r)) begin
                n_fail++;
                $display("FAIL round_robin_c%0d obs=%b exp=%b", k, obs, exp_v);
            end
        end
    endtask

    task automatic test_handover_drop();
        q_req = 0; r_req = 0;
        apply_reset();
        arb_en = 1; q_req = 1;
        @(negedge clk);
        r_req = 1;
        @(negedge clk);
        exp_v = {1'b1, 1'b0, 1'b1, 1'b0, 3'd1, 1'b0};
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL pre_drop obs=%b exp=%b", obs, exp_v);
        end
        q_req = 0;
        @(negedge clk);
        exp_v = {1'b0, 1'b1, 1'b1, 1'b1, 3'd0, 1'b1};
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL drop_handover obs=%b exp=%b", obs, exp_v);
        end
    endtask

    task automatic test_arb_disable();
        arb_en = 0;
        @(negedge clk);
        exp_v = {1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1};
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL arb_disable obs=%b exp=%b", obs, exp_v);
        end
        arb_en = 1; q_req = 1; r_req = 1;
        @(negedge clk);
        exp_v = {1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 1'b0};
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL reenable_tie obs=%b exp=%b", obs, exp_v);
        end
    endtask

    task automatic test_async_reset();
        q_req = 0; r_req = 0;
        apply_reset();
        arb_en = 1; q_req = 1; r_req = 1;
        repeat (3) @(negedge clk);
        exp_v = {1'b1, 1'b0, 1'b1, 1'b0, 3'd2, 1'b0};
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL pre_reset obs=%b exp=%b", obs, exp_v);
        end
        #2 rst_n = 1'b0;
        #1;
        exp_v = 8'b0000_000_1;
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL async_reset obs=%b exp=%b", obs, exp_v);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        exp_v = {1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 1'b0};
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL post_reset_tie obs=%b exp=%b", obs, exp_v);
        end
    endtask

    task automatic test_max_hold_one();
        arb_en1 = 1; q_req1 = 1; r_req1 = 1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            exp1 = {(k % 2 == 0), (k % 2 == 1), 1'b1, 1'b1, 1'b0, (k % 2 == 1)};
            n_tests++;
            if (obs1 !== exp1) begin
                n_fail++;
                $display("FAIL max_hold1_c%0d obs=%b exp=%b", k, obs1, exp1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_req();
        test_round_robin();
        test_handover_drop();
        test_arb_disable();
        test_async_reset();
        test_max_hold_one();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
